// File: rtl/vec_packer_pkg.sv
// rtl/vec_packer_pkg.sv - shared constants and helpers for the vector packer and product tree
package vec_packer_pkg;

  // IEEE-754 double 1.0, the multiplicative identity used for lane padding
  localparam logic [63:0] FP64_ONE = 64'h3FF0000000000000;

  // Width of the completed-packet counter
  localparam int PKT_CNT_W = 16;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vec_packer.sv
// rtl/vec_packer.sv - packs a tlast-delimited double stream into NUM-lane vectors with 1.0 padding
module vec_packer
  import vec_packer_pkg::*;
#(
  parameter int                    NUM        = 8,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(FP64_ONE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic [NUM*DATA_WIDTH-1:0]   dout,
  output logic [NUM-1:0]              dout_tvalid,
  output logic                        dout_last,
  output logic [clog2(NUM+1)-1:0]     dout_pad_cnt,
  output logic [PKT_CNT_W-1:0]        pkt_cnt
);

  localparam int LANE_W = clog2(NUM);
  localparam int PAD_W  = clog2(NUM + 1);

  logic [LANE_W-1:0]         lane_idx;
  logic [DATA_WIDTH-1:0]     fill_q [NUM-1];
  logic                      accept;
  logic                      complete;
  logic [NUM*DATA_WIDTH-1:0] vec_d;

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign complete = accept && ((lane_idx == LANE_W'(NUM - 1)) || s_axis_tlast);

  // Next vector: stored lanes below the current index, the live beat at it, padding above.
  // The top lane is never stored because a beat landing there always completes the vector.
  for (genvar k = 0; k < NUM; k++) begin : g_lane
    if (k < NUM - 1) begin : g_stored
      assign vec_d[k*DATA_WIDTH +: DATA_WIDTH] =
        (LANE_W'(k) < lane_idx)  ? fill_q[k]    :
        (LANE_W'(k) == lane_idx) ? s_axis_tdata : PAD_VALUE;
    end else begin : g_top
      assign vec_d[k*DATA_WIDTH +: DATA_WIDTH] =
        (LANE_W'(k) == lane_idx) ? s_axis_tdata : PAD_VALUE;
    end
  end

  // Fill register: capture each accepted beat into its lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM - 1; k++) begin
        fill_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM - 1; k++) begin
        if (accept && (lane_idx == LANE_W'(k))) begin
          fill_q[k] <= s_axis_tdata;
        end
      end
    end
  end

  // Lane index and ready: ready rises one edge after reset release and never drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx      <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (complete) begin
        lane_idx <= '0;
      end else if (accept) begin
        lane_idx <= lane_idx + LANE_W'(1);
      end
    end
  end

  // Output register: loads on a completing beat, valid pulses for one cycle, data holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout         <= '0;
      dout_tvalid  <= '0;
      dout_last    <= 1'b0;
      dout_pad_cnt <= '0;
      pkt_cnt      <= '0;
    end else begin
      dout_tvalid <= '0;
      if (complete) begin
        dout         <= vec_d;
        dout_tvalid  <= '1;
        dout_last    <= s_axis_tlast;
        dout_pad_cnt <= PAD_W'(NUM - 1) - PAD_W'(lane_idx);
        if (s_axis_tlast) begin
          pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
        end
      end
    end
  end

endmodule
